// File: rtl/follower_pkg.sv
// Definitions shared by the barcode receiver and its downstream consumer.
// Holds the receiver FSM encoding, the frame width and the accepted ID prefix.
package follower_pkg;

    localparam int ID_W = 8;

    // comProc only acts on station IDs whose two MSBs match this prefix
    localparam logic [1:0] ID_VALID_PREFIX = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_FALL = 3'd2,
        S_DELAY     = 3'd3,
        S_SAMPLE    = 3'd4,
        S_DONE      = 3'd5
    } bc_state_e;

endpackage

// File: rtl/barcode_rx_if.sv
// Station-ID handshake between barcode_rx (master) and comProc (slave).
interface barcode_rx_if #(
    parameter int ID_W = 8
) ();

    logic [ID_W-1:0] ID;
    logic            ID_vld;
    logic            clr_ID_vld;
    logic            busy;

    modport master (
        output ID,
        output ID_vld,
        output busy,
        input  clr_ID_vld
    );

    modport slave (
        input  ID,
        input  ID_vld,
        input  busy,
        output clr_ID_vld
    );

endinterface

// File: rtl/bc_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a falling-edge detector.
// All flops reset to 1 so an idle-high line produces no spurious edge.
module bc_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    // [0],[1] synchronizer stages, [2] previous synchronized value
    logic [2:0] pipe_q;
    logic [2:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1], pipe_q[0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '1;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign sync_out = pipe_q[1];
    assign fall     = pipe_q[2] & ~pipe_q[1];

endmodule

// File: rtl/barcode_rx.sv
// Self-timed barcode stripe decoder: measures the start-bit low time and samples each cell after that delay.
// Optional BC_TIMEOUT_EN aborts a frame whose next falling edge does not arrive within 4*T clocks.
module barcode_rx #(
    parameter int CNT_W = 22,
    parameter int ID_W  = follower_pkg::ID_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          BC,
    barcode_rx_if.master  rx_if
`ifdef BC_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    import follower_pkg::*;

    localparam int BIT_CNT_W = $clog2(ID_W + 1);

    logic bc_s;
    logic fall;

    bc_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (BC),
        .sync_out (bc_s),
        .fall     (fall)
    );

    bc_state_e            state_q, state_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic [CNT_W+1:0]     dly_q, dly_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ID_W-1:0]      shift_q, shift_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 id_vld_q, id_vld_d;
    logic                 load;

    // A zero-length measurement still needs at least one clock of delay
    logic [CNT_W-1:0]     t_eff;
    assign t_eff = (period_q == '0) ? CNT_W'(1) : period_q;

`ifdef BC_TIMEOUT_EN
    logic                 timeout_q, timeout_d;
    logic [CNT_W+1:0]     tmo_lim;
    assign tmo_lim = {t_eff, 2'b00};
`endif

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        dly_d     = dly_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        id_d      = id_q;
        id_vld_d  = id_vld_q;
        load      = 1'b0;
`ifdef BC_TIMEOUT_EN
        timeout_d = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d   = S_START;
                    period_d  = '0;
                    bit_cnt_d = '0;
`ifdef BC_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_START: begin
                if (!bc_s) begin
                    if (period_q != '1) begin
                        period_d = period_q + 1'b1;
                    end
                end else begin
                    state_d = S_WAIT_FALL;
                    dly_d   = '0;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    state_d = S_DELAY;
                    dly_d   = '0;
`ifdef BC_TIMEOUT_EN
                end else if (dly_q >= tmo_lim) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
`endif
                end
            end
            S_DELAY: begin
                // Falls inside the delay window are deliberately ignored
                if (dly_q == {2'b00, t_eff}) begin
                    state_d = S_SAMPLE;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                shift_d   = {shift_q[ID_W-2:0], bc_s};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(ID_W - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_FALL;
                    dly_d   = '0;
                end
            end
            S_DONE: begin
                load    = (shift_q[ID_W-1 -: 2] == ID_VALID_PREFIX);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load in the same cycle as a clear leaves the new ID valid
        if (rx_if.clr_ID_vld) begin
            id_vld_d = 1'b0;
        end
        if (load) begin
            id_vld_d = 1'b1;
            id_d     = shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            period_q  <= '0;
            dly_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            dly_q     <= dly_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            id_q      <= id_d;
            id_vld_q  <= id_vld_d;
        end
    end

`ifdef BC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign rx_if.ID     = id_q;
    assign rx_if.ID_vld = id_vld_q;
    assign rx_if.busy   = (state_q != S_IDLE);

endmodule
